// File: rtl/imem_load_arbiter.sv
// Instruction-memory arbiter: a byte-serial loader fills the single-port RAM
// word by word while the CPU is stalled; in RUN the CPU owns the RAM read port.
module imem_load_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        LoadStart,
    input  logic [7:0]  LoadBase,
    input  logic [8:0]  LoadCount,
    input  logic        LoadValid,
    input  logic [7:0]  LoadByte,
    output logic        LoadReady,
    output logic        LoadDone,
    input  logic        RunStart,
    input  logic        Halt,
    output logic        CpuStall,
    input  logic [31:0] FetchAddr,
    output logic [31:0] Instruction,
    output logic [7:0]  MemAddr,
    output logic        MemWe,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    output logic [8:0]  WordCount
);

    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, RUN} state_e;

    state_e      state_q, state_d;
    logic [7:0]  index_q, index_d;
    logic [8:0]  count_q, count_d;
    logic [8:0]  word_cnt_q, word_cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;

    // Only FetchAddr[9:2] addresses the 256-word RAM.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{FetchAddr[31:10], FetchAddr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            index_q    <= '0;
            count_q    <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        case (state_q)
            IDLE: begin
                if (LoadStart) begin
                    index_d    = LoadBase;
                    count_d    = LoadCount;
                    word_cnt_d = '0;
                    byte_idx_d = '0;
                    word_d     = '0;
                    state_d    = (LoadCount == 9'd0) ? DONE : COLLECT;
                end else if (RunStart) begin
                    state_d = RUN;
                end
            end
            COLLECT: begin
                if (Halt) begin
                    byte_idx_d = '0;
                    word_d     = '0;
                    state_d    = IDLE;
                end else if (LoadValid) begin
                    // Shift-in gives big-endian order: first byte ends in [31:24].
                    word_d     = {word_q[23:0], LoadByte};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                word_d = '0;
                if (Halt) begin
                    state_d = IDLE;
                end else begin
                    index_d    = index_q + 8'd1;
                    word_cnt_d = word_cnt_q + 9'd1;
                    state_d    = (word_cnt_q + 9'd1 == count_q) ? DONE : COLLECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            RUN: begin
                if (Halt) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign LoadReady   = (state_q == COLLECT);
    assign LoadDone    = (state_q == DONE);
    assign CpuStall    = (state_q != RUN);
    // An abort arriving during WRITE suppresses the strobe in that same cycle.
    assign MemWe       = (state_q == WRITE) && !Halt;
    assign MemWData    = (state_q == WRITE) ? word_q : 32'h0000_0000;
    assign MemAddr     = (state_q == RUN) ? FetchAddr[9:2] : index_q;
    assign Instruction = (state_q == RUN) ? MemRData : 32'h0000_0000;
    assign WordCount   = word_cnt_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter with a behavioural RAM and write/done monitors.
module tb_imem_load_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        LoadStart;
    logic [7:0]  LoadBase;
    logic [8:0]  LoadCount;
    logic        LoadValid;
    logic [7:0]  LoadByte;
    logic        LoadReady;
    logic        LoadDone;
    logic        RunStart;
    logic        Halt;
    logic        CpuStall;
    logic [31:0] FetchAddr;
    logic [31:0] Instruction;
    logic [7:0]  MemAddr;
    logic        MemWe;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic [8:0]  WordCount;

    logic [31:0] ram [256];
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_base;
    int          done_base;

    always #5 clk = ~clk;

    imem_load_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .LoadStart  (LoadStart),
        .LoadBase   (LoadBase),
        .LoadCount  (LoadCount),
        .LoadValid  (LoadValid),
        .LoadByte   (LoadByte),
        .LoadReady  (LoadReady),
        .LoadDone   (LoadDone),
        .RunStart   (RunStart),
        .Halt       (Halt),
        .CpuStall   (CpuStall),
        .FetchAddr  (FetchAddr),
        .Instruction(Instruction),
        .MemAddr    (MemAddr),
        .MemWe      (MemWe),
        .MemWData   (MemWData),
        .MemRData   (MemRData),
        .WordCount  (WordCount)
    );

    assign MemRData = ram[MemAddr];

    always @(posedge clk) begin
        if (MemWe) begin
            ram[MemAddr] <= MemWData;
            wr_cnt       <= wr_cnt + 1;
        end
        if (LoadDone) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [7:0] base, input logic [8:0] count);
        LoadStart = 1'b1;
        LoadBase  = base;
        LoadCount = count;
        tick();
        LoadStart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited    = 0;
        LoadValid = 1'b1;
        LoadByte  = b;
        while (!LoadReady && waited < 8) begin
            tick();
            waited++;
        end
        if (!LoadReady) begin
            check_val("ready_timeout", {31'd0, LoadReady}, 32'd1);
        end
        tick();
        LoadValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] tmp;
        tmp = w;
        send_byte(tmp[31:24]);
        send_byte(tmp[23:16]);
        send_byte(tmp[15:8]);
        send_byte(tmp[7:0]);
    endtask

    initial begin
        rst_n     = 1'b0;
        LoadStart = 1'b0;
        LoadBase  = '0;
        LoadCount = '0;
        LoadValid = 1'b0;
        LoadByte  = '0;
        RunStart  = 1'b0;
        Halt      = 1'b0;
        FetchAddr = '0;
        tick();
        tick();
        check_val("rst_stall",  {31'd0, CpuStall},  32'd1);
        check_val("rst_ready",  {31'd0, LoadReady}, 32'd0);
        check_val("rst_done",   {31'd0, LoadDone},  32'd0);
        check_val("rst_we",     {31'd0, MemWe},     32'd0);
        check_val("rst_wdata",  MemWData,           32'd0);
        check_val("rst_wcnt",   {23'd0, WordCount}, 32'd0);
        check_val("rst_instr",  Instruction,        32'd0);
        rst_n = 1'b1;
        tick();

        // Two-word load at base 0
        wr_base = wr_cnt;
        start_load(8'd0, 9'd2);
        check_val("t1_ready", {31'd0, LoadReady}, 32'd1);
        send_word(32'h2008_0005);
        check_val("t1_w0_we",   {31'd0, MemWe}, 32'd1);
        check_val("t1_w0_addr", {24'd0, MemAddr}, 32'd0);
        check_val("t1_w0_data", MemWData, 32'h2008_0005);
        send_word(32'h2009_000A);
        check_val("t1_w1_we",   {31'd0, MemWe}, 32'd1);
        check_val("t1_w1_addr", {24'd0, MemAddr}, 32'd1);
        check_val("t1_w1_data", MemWData, 32'h2009_000A);
        tick();
        check_val("t1_done",  {31'd0, LoadDone},  32'd1);
        check_val("t1_wcnt",  {23'd0, WordCount}, 32'd2);
        tick();
        check_val("t1_done_clr", {31'd0, LoadDone}, 32'd0);
        check_val("t1_nwrites", wr_cnt - wr_base, 32'd2);
        check_val("t1_ram0", ram[0], 32'h2008_0005);
        check_val("t1_ram1", ram[1], 32'h2009_000A);

        // Index wrap 255 -> 0
        start_load(8'd255, 9'd2);
        send_word(32'h1122_3344);
        check_val("t2_w0_addr", {24'd0, MemAddr}, 32'd255);
        send_word(32'h5566_7788);
        check_val("t2_w1_addr", {24'd0, MemAddr}, 32'd0);
        check_val("t2_w1_data", MemWData, 32'h5566_7788);
        tick();
        check_val("t2_done", {31'd0, LoadDone}, 32'd1);
        tick();
        check_val("t2_ram255", ram[255], 32'h1122_3344);
        check_val("t2_ram0",   ram[0],   32'h5566_7788);

        // Zero-length session
        wr_base = wr_cnt;
        start_load(8'd7, 9'd0);
        check_val("t3_done",  {31'd0, LoadDone},  32'd1);
        check_val("t3_we",    {31'd0, MemWe},     32'd0);
        check_val("t3_wcnt",  {23'd0, WordCount}, 32'd0);
        tick();
        check_val("t3_done_clr", {31'd0, LoadDone}, 32'd0);
        check_val("t3_nwrites",  wr_cnt - wr_base, 32'd0);

        // Abort mid-word during a three-word load
        wr_base   = wr_cnt;
        done_base = done_cnt;
        start_load(8'd9, 9'd3);
        send_word(32'hCAFE_F00D);
        check_val("t4_w0_addr", {24'd0, MemAddr}, 32'd9);
        send_byte(8'h01);
        send_byte(8'h02);
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        check_val("t4_ready", {31'd0, LoadReady}, 32'd0);
        check_val("t4_wcnt",  {23'd0, WordCount}, 32'd1);
        check_val("t4_done",  {31'd0, LoadDone},  32'd0);
        LoadValid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        LoadValid = 1'b0;
        check_val("t4_nwrites", wr_cnt - wr_base, 32'd1);
        check_val("t4_ndone",   done_cnt - done_base, 32'd0);

        // CPU run and LoadStart ignored in RUN
        FetchAddr = 32'h0000_0024;
        RunStart  = 1'b1;
        tick();
        RunStart = 1'b0;
        check_val("t5_stall", {31'd0, CpuStall}, 32'd0);
        check_val("t5_addr",  {24'd0, MemAddr},  32'd9);
        check_val("t5_instr", Instruction, 32'hCAFE_F00D);
        check_val("t5_we",    {31'd0, MemWe}, 32'd0);
        start_load(8'd0, 9'd1);
        check_val("t5_ign_stall", {31'd0, CpuStall},  32'd0);
        check_val("t5_ign_ready", {31'd0, LoadReady}, 32'd0);
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        check_val("t5_halt_stall", {31'd0, CpuStall}, 32'd1);
        check_val("t5_halt_instr", Instruction, 32'd0);

        // Reset during COLLECT with LoadValid held
        wr_base = wr_cnt;
        start_load(8'd0, 9'd2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        LoadValid = 1'b1;
        LoadByte  = 8'hCC;
        rst_n     = 1'b0;
        #1;
        check_val("t6_ready", {31'd0, LoadReady}, 32'd0);
        check_val("t6_stall", {31'd0, CpuStall},  32'd1);
        check_val("t6_we",    {31'd0, MemWe},     32'd0);
        check_val("t6_wcnt",  {23'd0, WordCount}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        LoadValid = 1'b0;
        check_val("t6_ready_after", {31'd0, LoadReady}, 32'd0);
        check_val("t6_nwrites", wr_cnt - wr_base, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_load_arbiter.md
IMEM_LOAD_ARBITER -- requirements
Module: imem_load_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have port LoadStart, input, 1 bit, single-cycle request to begin a program-load session.
REQ-004 The block SHALL have port LoadBase, input, 8 bits, first word index to write; sampled on the accepted LoadStart.
REQ-005 The block SHALL have port LoadCount, input, 9 bits, words to load, 0..256; sampled on the accepted LoadStart.
REQ-006 The block SHALL have port LoadValid, input, 1 bit, loader byte valid.
REQ-007 The block SHALL have port LoadByte, input, 8 bits, loader byte data.
REQ-008 The block SHALL have port LoadReady, output, 1 bit, block accepts a byte this cycle.
REQ-009 The block SHALL have port LoadDone, output, 1 bit, one-cycle pulse when a session completes.
REQ-010 The block SHALL have port RunStart, input, 1 bit, release the CPU to fetch.
REQ-011 The block SHALL have port Halt, input, 1 bit, stop the CPU or abort a load.
REQ-012 The block SHALL have port CpuStall, output, 1 bit, CPU PC must hold.
REQ-013 The block SHALL have port FetchAddr, input, 32 bits, CPU byte address of the fetch.
REQ-014 The block SHALL have port Instruction, output, 32 bits, instruction word to the CPU.
REQ-015 The block SHALL have port MemAddr, output, 8 bits, word index to the single-port instruction RAM.
REQ-016 The block SHALL have ports MemWe, output, 1 bit, and MemWData, output, 32 bits; together they form the RAM write strobe and data.
REQ-017 The block SHALL have port MemRData, input, 32 bits, combinational RAM read data at MemAddr.
REQ-018 The block SHALL have port WordCount, output, 9 bits, words written in the current or last session.

Function
REQ-019 The FSM SHALL have states IDLE, COLLECT, WRITE, DONE, RUN.
REQ-020 In IDLE, LoadStart SHALL capture LoadBase and LoadCount, clear WordCount and the byte index, and go to COLLECT; if LoadCount=0 it SHALL go to DONE instead.
REQ-021 In IDLE, RunStart without LoadStart SHALL go to RUN; when both are asserted, LoadStart SHALL win.
REQ-022 LoadReady SHALL be 1 only in COLLECT; a byte is accepted when LoadValid and LoadReady are both 1.
REQ-023 Bytes SHALL be assembled big-endian: the first accepted byte goes to [31:24] and the fourth to [7:0].
REQ-024 The 4th accepted byte SHALL move the FSM to WRITE.
REQ-025 WRITE SHALL last exactly one cycle, with MemWe=1, MemAddr=current index and MemWData=assembled word.
REQ-026 On leaving WRITE, the index SHALL increment modulo 256 (255 wraps to 0), WordCount SHALL increment, and the FSM SHALL go to DONE if WordCount reaches LoadCount, else to COLLECT.
REQ-027 DONE SHALL last one cycle with LoadDone=1 and then return to IDLE.
REQ-028 CpuStall SHALL be 1 in every state except RUN.
REQ-029 In RUN, MemAddr SHALL equal FetchAddr[9:2], Instruction SHALL equal MemRData, and MemWe SHALL be 0.
REQ-030 Outside RUN, Instruction SHALL be 32'h00000000 (NOP).
REQ-031 In RUN, LoadStart SHALL be ignored; Halt SHALL return the FSM to IDLE.
REQ-032 Halt in COLLECT or WRITE SHALL abort the session: no write in that cycle, the partial word is discarded, the FSM goes to IDLE, LoadDone stays 0, and WordCount keeps the count of words already written.
REQ-033 LoadStart outside IDLE SHALL be ignored.
REQ-034 Outside RUN and WRITE, MemAddr SHALL equal the current load index.

Reset
REQ-035 While rst_n=0, the block SHALL hold state=IDLE, CpuStall=1, LoadReady=0, LoadDone=0, MemWe=0, MemWData=0, WordCount=0, Instruction=0, and clear the index and the byte assembly register.
REQ-036 Reset asserted mid-session SHALL discard any partial word, and no MemWe pulse SHALL occur until a new session is started.

Verification
REQ-037 A bench SHALL cover: LoadStart with Base=0, Count=2, then bytes 20,08,00,05,20,09,00,0A -> writes 0x20080005 @0 and 0x2009000A @1, one MemWe cycle each, LoadDone pulse, WordCount=2.
REQ-038 A bench SHALL cover: Base=255, Count=2 -> writes at indices 255 then 0 (wrap).
REQ-039 A bench SHALL cover: Count=0 -> LoadDone on the cycle after LoadStart, no MemWe, WordCount=0.
REQ-040 A bench SHALL cover: Halt after the 2nd byte of word 1 of a 3-word load -> no further MemWe, IDLE, WordCount=1, LoadDone=0.
REQ-041 A bench SHALL cover: RunStart with FetchAddr=0x24 -> MemAddr=9, Instruction=MemRData, CpuStall=0; then LoadStart in RUN -> ignored.
REQ-042 A bench SHALL cover: rst_n low mid-COLLECT with LoadValid held high -> LoadReady=0, CpuStall=1, and no write after release.
